// File: rtl/wordle_pkg.sv
// Shared constants, colour codes and FSM state encoding for the Wordle row buffer.
package wordle_pkg;

    localparam int LETTER_W = 5;
    localparam int WORD_LEN = 5;

    localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd0;
    localparam logic [LETTER_W-1:0] LETTER_MAX   = 5'd26;

    localparam logic [1:0] COL_GREY   = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;
    localparam logic [1:0] COL_CURSOR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_COMMIT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    // Codes above Z have no letter meaning and are stored as blank.
    function automatic logic [LETTER_W-1:0] sanitize_letter(input logic [LETTER_W-1:0] code);
        if (code > LETTER_MAX) begin
            return LETTER_BLANK;
        end else begin
            return code;
        end
    endfunction

endpackage

// File: rtl/wordle_rise_detect.sv
// Rising-edge detector with one registered copy of the input; suppresses an edge
// for a level already high when reset is released.
module wordle_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_d;
    logic armed_q;
    logic armed_d;

    // Next-state for the delayed copy and the post-reset arm flag.
    always_comb begin
        sig_d   = sig;
        armed_d = 1'b1;
    end

    // Edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sig_q   <= sig_d;
            armed_q <= armed_d;
        end
    end

    assign rise = armed_q & sig & ~sig_q;

endmodule

// File: rtl/wordle_row_buffer.sv
// Five-slot guess row: captures letters, scores the row against the target with
// Wordle duplicate rules using one sequential comparator, and tracks game progress.
module wordle_row_buffer
    import wordle_pkg::*;
#(
    parameter int MAX_ROWS = 6
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        submitted,
    input  logic [2:0]  column,
    input  logic [6:0]  value,
    input  logic        check,
    input  logic [24:0] target_flat,
    output logic [34:0] row_values_flat,
    output logic [34:0] result_flat,
    output logic        result_valid,
    output logic        busy,
    output logic        invalid,
    output logic [2:0]  row_index,
    output logic        solved,
    output logic        game_over
);

    localparam logic [2:0] MAX_ROWS_C = 3'(MAX_ROWS);

    state_t state_q, state_d;
    logic [2:0] idx_i_q, idx_i_d, idx_j_q, idx_j_d;
    logic [WORD_LEN-1:0][LETTER_W-1:0] slots_q, slots_d, target_q, target_d;
    logic [WORD_LEN-1:0][1:0] colour_q, colour_d;
    logic [WORD_LEN-1:0] used_q, used_d;
    logic [34:0] result_q, result_d;
    logic result_valid_q, result_valid_d, busy_q, busy_d, invalid_q, invalid_d;
    logic solved_q, solved_d, game_over_q, game_over_d;
    logic [2:0] row_index_q, row_index_d;

    logic submit_rise_s, check_rise_s;
    logic [LETTER_W-1:0] cmp_guess_s, cmp_target_s;
    logic letters_match_s, all_full_s, all_green_s;
    logic unused_value_s;

    assign unused_value_s = ^value[6:5];

    wordle_rise_detect u_submit_rise (
        .clk  (clk),
        .rst_n(clr_n),
        .sig  (submitted),
        .rise (submit_rise_s)
    );

    wordle_rise_detect u_check_rise (
        .clk  (clk),
        .rst_n(clr_n),
        .sig  (check),
        .rise (check_rise_s)
    );

    // Single shared comparator: GREEN pairs guess[i]/target[i], YELLOW guess[i]/target[j].
    always_comb begin
        cmp_guess_s = slots_q[idx_i_q];
        if (state_q == ST_YELLOW) begin
            cmp_target_s = target_q[idx_j_q];
        end else begin
            cmp_target_s = target_q[idx_i_q];
        end
        letters_match_s = (cmp_guess_s == cmp_target_s);
    end

    // Row-wide summaries: every slot filled, every colour green.
    always_comb begin
        all_full_s  = 1'b1;
        all_green_s = 1'b1;
        for (int k = 0; k < WORD_LEN; k++) begin
            if (slots_q[k] == LETTER_BLANK) begin
                all_full_s = 1'b0;
            end else begin
                all_full_s = all_full_s;
            end
            if (colour_q[k] != COL_GREEN) begin
                all_green_s = 1'b0;
            end else begin
                all_green_s = all_green_s;
            end
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d        = state_q;
        idx_i_d        = idx_i_q;
        idx_j_d        = idx_j_q;
        slots_d        = slots_q;
        target_d       = target_q;
        colour_d       = colour_q;
        used_d         = used_q;
        result_d       = result_q;
        row_index_d    = row_index_q;
        solved_d       = solved_q;
        game_over_d    = game_over_q;
        result_valid_d = 1'b0;
        invalid_d      = 1'b0;
        busy_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A simultaneous check edge is dropped in favour of the write.
                if (submit_rise_s) begin
                    if (column <= 3'd4) begin
                        slots_d[column] = sanitize_letter(value[4:0]);
                    end else begin
                        slots_d = slots_q;
                    end
                end else if (check_rise_s) begin
                    if (!all_full_s) begin
                        invalid_d = 1'b1;
                    end else begin
                        target_d = target_flat;
                        colour_d = '0;
                        used_d   = '0;
                        idx_i_d  = 3'd0;
                        idx_j_d  = 3'd0;
                        busy_d   = 1'b1;
                        state_d  = ST_GREEN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GREEN: begin
                busy_d = 1'b1;
                if (letters_match_s) begin
                    colour_d[idx_i_q] = COL_GREEN;
                    used_d[idx_i_q]   = 1'b1;
                end else begin
                    colour_d = colour_q;
                end
                if (idx_i_q == 3'd4) begin
                    idx_i_d = 3'd0;
                    idx_j_d = 3'd0;
                    state_d = ST_YELLOW;
                end else begin
                    idx_i_d = idx_i_q + 3'd1;
                end
            end
            ST_YELLOW: begin
                busy_d = 1'b1;
                if ((colour_q[idx_i_q] == COL_GREY) && !used_q[idx_j_q] && letters_match_s) begin
                    colour_d[idx_i_q] = COL_YELLOW;
                    used_d[idx_j_q]   = 1'b1;
                end else begin
                    colour_d = colour_q;
                end
                if (idx_j_q == 3'd4) begin
                    idx_j_d = 3'd0;
                    if (idx_i_q == 3'd4) begin
                        idx_i_d = 3'd0;
                        state_d = ST_COMMIT;
                    end else begin
                        idx_i_d = idx_i_q + 3'd1;
                    end
                end else begin
                    idx_j_d = idx_j_q + 3'd1;
                end
            end
            ST_COMMIT: begin
                busy_d         = 1'b1;
                result_valid_d = 1'b1;
                for (int k = 0; k < WORD_LEN; k++) begin
                    result_d[7*k +: 7] = {colour_q[k], slots_q[k]};
                end
                row_index_d = row_index_q + 3'd1;
                solved_d    = all_green_s;
                slots_d     = '0;
                if (all_green_s || ((row_index_q + 3'd1) == MAX_ROWS_C)) begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                game_over_d = 1'b1;
                state_d     = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= ST_IDLE;
            idx_i_q        <= 3'd0;
            idx_j_q        <= 3'd0;
            slots_q        <= '0;
            target_q       <= '0;
            colour_q       <= '0;
            used_q         <= '0;
            result_q       <= 35'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            invalid_q      <= 1'b0;
            row_index_q    <= 3'd0;
            solved_q       <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_i_q        <= idx_i_d;
            idx_j_q        <= idx_j_d;
            slots_q        <= slots_d;
            target_q       <= target_d;
            colour_q       <= colour_d;
            used_q         <= used_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            invalid_q      <= invalid_d;
            row_index_q    <= row_index_d;
            solved_q       <= solved_d;
            game_over_q    <= game_over_d;
        end
    end

    // Row image for the selection stage: slot letters padded to 7 bits.
    always_comb begin
        row_values_flat = 35'd0;
        for (int k = 0; k < WORD_LEN; k++) begin
            row_values_flat[7*k +: 7] = {2'b00, slots_q[k]};
        end
    end

    assign result_flat  = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign invalid      = invalid_q;
    assign row_index    = row_index_q;
    assign solved       = solved_q;
    assign game_over    = game_over_q;

endmodule
